// File: rtl/controlador_despacho_if.sv
// Dispense-sequencer bus: credit events, slot/restock requests, sensor in; motor, coin and status out.
// The master drives stimulus and requests, the slave is the dispense sequencer.
interface controlador_despacho_if #(
  parameter int unsigned NUM_SLOTS = 4
);
  logic                 credito_valido;
  logic [2:0]           credito;
  logic [1:0]           seleccion;
  logic                 sensor;
  logic                 reponer;
  logic [1:0]           slot_reponer;
  logic [NUM_SLOTS-1:0] motor;
  logic                 moneda_cambio;
  logic                 vendido;
  logic                 error;
  logic                 ocupado;
  logic [NUM_SLOTS-1:0] agotado;

  modport master (
    output credito_valido, credito, seleccion, sensor, reponer, slot_reponer,
    input  motor, moneda_cambio, vendido, error, ocupado, agotado
  );

  modport slave (
    input  credito_valido, credito, seleccion, sensor, reponer, slot_reponer,
    output motor, moneda_cambio, vendido, error, ocupado, agotado
  );
endinterface

// File: rtl/controlador_despacho.sv
// Dispense sequencer: validates a credit event against price and stock, pulses the slot motor,
// waits for the drop sensor with a timeout, then pays change or a refund one coin at a time.
module controlador_despacho #(
  parameter int unsigned NUM_SLOTS    = 4,
  parameter int unsigned PRECIO       = 3,
  parameter int unsigned STOCK_MAX    = 7,
  parameter int unsigned MOTOR_CYCLES = 4,
  parameter int unsigned TIMEOUT      = 16
) (
  input logic                    clk,
  input logic                    reset,
  controlador_despacho_if.slave  bus_if
);

  localparam int unsigned CRED_W  = 3;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned STOCK_W = 4;
  localparam int unsigned CNT_W   = 8;

  localparam logic [CRED_W-1:0]  PRECIO_C   = CRED_W'(PRECIO);
  localparam logic [STOCK_W-1:0] STOCK_INIT = STOCK_W'(STOCK_MAX);
  localparam logic [CNT_W-1:0]   MOT_LAST   = CNT_W'(MOTOR_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST    = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    DISPENSE,
    WAIT_SENSOR,
    CAMBIO
  } state_e;

  state_e               state_q;
  logic [CRED_W-1:0]    cred_q;
  logic [SEL_W-1:0]     sel_q;
  logic [CRED_W-1:0]    cambio_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 fase_q;
  logic [NUM_SLOTS-1:0] motor_q;
  logic                 moneda_q;
  logic                 vendido_q;
  logic                 error_q;
  logic                 ocupado_q;
  logic [STOCK_W-1:0]   stock_q [NUM_SLOTS];
  logic [STOCK_W-1:0]   stock_d [NUM_SLOTS];

  logic [STOCK_W-1:0]   stock_sel_c;
  logic [NUM_SLOTS-1:0] motor_sel_c;
  logic                 compra_ok_c;
  logic                 dec_en_c;
  logic [NUM_SLOTS-1:0] agotado_c;

  // Selected-slot decode; a selection with no matching slot reads as empty stock and is refunded.
  always_comb begin
    stock_sel_c = '0;
    motor_sel_c = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (sel_q == SEL_W'(i)) begin
        stock_sel_c    = stock_q[i];
        motor_sel_c[i] = 1'b1;
      end
    end
    compra_ok_c = (stock_sel_c != '0) && (cred_q >= PRECIO_C);
    dec_en_c    = (state_q == CHECK) && compra_ok_c;
  end

  // Stock next state: restock is applied last so it overrides a same-cycle decrement.
  always_comb begin
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      stock_d[i] = stock_q[i];
      if (dec_en_c && (sel_q == SEL_W'(i)) && (stock_q[i] != '0)) begin
        stock_d[i] = stock_q[i] - STOCK_W'(1);
      end
      if (bus_if.reponer && (bus_if.slot_reponer == SEL_W'(i))) begin
        stock_d[i] = STOCK_INIT;
      end
    end
  end

  always_comb begin
    agotado_c = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      agotado_c[i] = (stock_q[i] == '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cred_q    <= '0;
      sel_q     <= '0;
      cambio_q  <= '0;
      cnt_q     <= '0;
      fase_q    <= 1'b0;
      motor_q   <= '0;
      moneda_q  <= 1'b0;
      vendido_q <= 1'b0;
      error_q   <= 1'b0;
      ocupado_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        stock_q[i] <= STOCK_INIT;
      end
    end else begin
      stock_q   <= stock_d;
      vendido_q <= 1'b0;
      error_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus_if.credito_valido && (bus_if.credito != '0)) begin
            cred_q    <= bus_if.credito;
            sel_q     <= bus_if.seleccion;
            ocupado_q <= 1'b1;
            state_q   <= CHECK;
          end
        end
        CHECK: begin
          fase_q <= 1'b0;
          if (compra_ok_c) begin
            cambio_q <= cred_q - PRECIO_C;
            motor_q  <= motor_sel_c;
            cnt_q    <= '0;
            state_q  <= DISPENSE;
          end else begin
            cambio_q <= cred_q;
            state_q  <= CAMBIO;
          end
        end
        DISPENSE: begin
          if (cnt_q == MOT_LAST) begin
            motor_q <= '0;
            cnt_q   <= '0;
            state_q <= WAIT_SENSOR;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WAIT_SENSOR: begin
          // A drop seen on the final allowed cycle still counts as a sale.
          if (bus_if.sensor) begin
            vendido_q <= 1'b1;
            fase_q    <= 1'b0;
            state_q   <= CAMBIO;
          end else if (cnt_q == TO_LAST) begin
            error_q  <= 1'b1;
            cambio_q <= cred_q;
            fase_q   <= 1'b0;
            state_q  <= CAMBIO;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        CAMBIO: begin
          if (fase_q) begin
            moneda_q <= 1'b0;
            fase_q   <= 1'b0;
          end else if (cambio_q == '0) begin
            ocupado_q <= 1'b0;
            state_q   <= IDLE;
          end else begin
            moneda_q <= 1'b1;
            cambio_q <= cambio_q - CRED_W'(1);
            fase_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus_if.motor         = motor_q;
  assign bus_if.moneda_cambio = moneda_q;
  assign bus_if.vendido       = vendido_q;
  assign bus_if.error         = error_q;
  assign bus_if.ocupado       = ocupado_q;
  assign bus_if.agotado       = agotado_c;

endmodule

// File: tb/tb_controlador_despacho.sv
// Bench for controlador_despacho: two instances (STOCK_MAX 7 and 2); expected transaction
// summaries are queued when a purchase is driven and checked when the DUT goes idle.
module tb_controlador_despacho;

  typedef struct {
    int dut;
    int mor;
    int mcnt;
    int mfirst;
    int vcnt;
    int vcyc;
    int ecnt;
    int ecyc;
    int ccnt;
    int endc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int unsigned cyc = 0;
  int unsigned t0 = 0;
  int          vectors = 0;
  int          miscmp = 0;
  exp_t        sb[$];
  int          stk [2][4];

  logic       cv  [2];
  logic [2:0] cr  [2];
  logic [1:0] sl  [2];
  logic       sn  [2];
  logic       rp  [2];
  logic [1:0] rs  [2];
  logic [3:0] mot [2];
  logic [3:0] agt [2];
  logic       ocup[2];
  logic       mon [2];
  logic       vend[2];
  logic       err [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, int obs, int exp);
    vectors++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    controlador_despacho_if #(.NUM_SLOTS(4)) bus ();

    controlador_despacho #(
      .NUM_SLOTS(4), .PRECIO(3), .STOCK_MAX(g == 0 ? 7 : 2), .MOTOR_CYCLES(4), .TIMEOUT(16)
    ) dut (
      .clk(clk),
      .reset(reset),
      .bus_if(bus)
    );

    assign bus.credito_valido = cv[g];
    assign bus.credito        = cr[g];
    assign bus.seleccion      = sl[g];
    assign bus.sensor         = sn[g];
    assign bus.reponer        = rp[g];
    assign bus.slot_reponer   = rs[g];
    assign mot[g]  = bus.motor;
    assign agt[g]  = bus.agotado;
    assign ocup[g] = bus.ocupado;
    assign mon[g]  = bus.moneda_cambio;
    assign vend[g] = bus.vendido;
    assign err[g]  = bus.error;

    // Collects one transaction summary per busy period and scores it against the queue head.
    initial begin : monitor
      int unsigned rel;
      int mcnt, mfirst, vcnt, vcyc, ecnt, ecyc, ccnt;
      int mor;
      bit act, prev, bad;
      exp_t e;
      act = 0;
      forever begin
        @(negedge clk);
        rel = cyc - t0;
        if (!reset) begin
          act = 0;
        end else begin
          if (!act && ocup[g]) begin
            act = 1; mcnt = 0; mfirst = 0; vcnt = 0; vcyc = 0; ecnt = 0; ecyc = 0;
            ccnt = 0; mor = 0; prev = 0; bad = 0;
          end
          if (act) begin
            if (mot[g] != 4'd0) begin
              if (mcnt == 0) mfirst = int'(rel);
              mcnt++;
              mor = mor | int'(mot[g]);
              if ($countones(mot[g]) != 1) bad = 1;
            end
            if (vend[g]) begin vcnt++; vcyc = int'(rel); end
            if (err[g])  begin ecnt++; ecyc = int'(rel); end
            if (mon[g]) begin
              if (prev) bad = 1;
              ccnt++;
            end
            prev = mon[g];
            if (!ocup[g]) begin
              act = 0;
              chk($sformatf("d%0d_sb_nonempty", g), int'(sb.size() != 0), 1);
              if (sb.size() != 0) begin
                e = sb.pop_front();
                chk($sformatf("d%0d_dut_id", g), g, e.dut);
                chk($sformatf("d%0d_motor_bits", g), mor, e.mor);
                chk($sformatf("d%0d_motor_cycles", g), mcnt, e.mcnt);
                chk($sformatf("d%0d_motor_first", g), mfirst, e.mfirst);
                chk($sformatf("d%0d_vendido_cnt", g), vcnt, e.vcnt);
                chk($sformatf("d%0d_vendido_cyc", g), vcyc, e.vcyc);
                chk($sformatf("d%0d_error_cnt", g), ecnt, e.ecnt);
                chk($sformatf("d%0d_error_cyc", g), ecyc, e.ecyc);
                chk($sformatf("d%0d_coins", g), ccnt, e.ccnt);
                chk($sformatf("d%0d_end_cyc", g), int'(rel), e.endc);
                chk($sformatf("d%0d_shape_bad", g), int'(bad), 0);
              end
            end
          end
        end
      end
    end
  end

  function automatic int smax(int d);
    return (d == 0) ? 7 : 2;
  endfunction

  function automatic int agot_model(int d);
    int a;
    a = 0;
    for (int i = 0; i < 4; i++) if (stk[d][i] == 0) a = a | (1 << i);
    return a;
  endfunction

  // Reference model of one purchase; cycle numbers are relative to the credit cycle.
  function automatic exp_t model(int d, int credit, int sel, int k, bit repo);
    exp_t e;
    int c;
    e = '{default: 0};
    e.dut = d;
    if (stk[d][sel] > 0 && credit >= 3) begin
      stk[d][sel] = stk[d][sel] - 1;
      e.mor = 1 << sel; e.mcnt = 4; e.mfirst = 2;
      if (k >= 1 && k <= 16) begin
        e.vcnt = 1; e.vcyc = 6 + k; c = 6 + k; e.ccnt = credit - 3;
      end else begin
        e.ecnt = 1; e.ecyc = 22; c = 22; e.ccnt = credit;
      end
    end else begin
      c = 2; e.ccnt = credit;
    end
    if (repo) stk[d][sel] = smax(d);
    e.endc = c + 2 * e.ccnt + 1;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic buy(int d, int credit, int sel, int k, bit extra, bit repo);
    int n;
    int unsigned rel;
    sb.push_back(model(d, credit, sel, k, repo));
    cv[d] = 1'b1; cr[d] = 3'(credit); sl[d] = 2'(sel);
    t0 = cyc;
    n = 0;
    do begin
      tick();
      n++;
      rel = cyc - t0;
      if (extra && rel == 3) begin
        cv[d] = 1'b1; cr[d] = 3'd7; sl[d] = 2'd0;
      end else begin
        cv[d] = 1'b0;
      end
      sn[d] = (k > 0) && (rel == 32'(5 + k));
      rp[d] = repo && (rel == 1);
      rs[d] = 2'(sel);
    end while ((ocup[d] || n < 2) && n < 200);
    cv[d] = 1'b0; sn[d] = 1'b0; rp[d] = 1'b0;
    chk($sformatf("d%0d_idle_within_bound", d), int'(n < 200), 1);
    tick();
  endtask

  task automatic restock(int d, int slot);
    rp[d] = 1'b1; rs[d] = 2'(slot);
    stk[d][slot] = smax(d);
    tick();
    rp[d] = 1'b0;
    tick();
  endtask

  initial begin
    int coins;
    for (int d = 0; d < 2; d++) begin
      cv[d] = 0; cr[d] = 0; sl[d] = 0; sn[d] = 0; rp[d] = 0; rs[d] = 0;
      for (int i = 0; i < 4; i++) stk[d][i] = smax(d);
    end
    #1 reset = 1'b0;
    #2;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_rst_motor", d), int'(mot[d]), 0);
      chk($sformatf("d%0d_rst_moneda", d), int'(mon[d]), 0);
      chk($sformatf("d%0d_rst_ocupado", d), int'(ocup[d]), 0);
      chk($sformatf("d%0d_rst_agotado", d), int'(agt[d]), agot_model(d));
      chk($sformatf("d%0d_rst_vendido", d), int'(vend[d]), 0);
      chk($sformatf("d%0d_rst_error", d), int'(err[d]), 0);
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    tick();

    // credito ignored when zero
    cv[0] = 1'b1; cr[0] = 3'd0; sl[0] = 2'd1;
    tick(); cv[0] = 1'b0;
    tick();
    chk("d0_zero_credit_idle", int'(ocup[0]), 0);

    buy(0, 5, 1, 3, 0, 0);
    buy(0, 2, 0, 0, 0, 0);
    buy(0, 4, 2, 0, 0, 0);
    buy(0, 6, 3, 2, 1, 0);
    buy(0, 7, 0, 16, 0, 0);
    chk("d0_agotado_after_sales", int'(agt[0]), agot_model(0));

    buy(1, 3, 0, 2, 0, 0);
    buy(1, 3, 0, 1, 0, 0);
    chk("d1_agotado_empty", int'(agt[1]), agot_model(1));
    buy(1, 3, 0, 0, 0, 0);
    restock(1, 0);
    chk("d1_agotado_restocked", int'(agt[1]), agot_model(1));
    buy(1, 3, 0, 2, 0, 1);
    buy(1, 5, 0, 4, 0, 0);
    chk("d1_agotado_collision", int'(agt[1]), agot_model(1));
    buy(1, 3, 0, 2, 0, 0);
    chk("d1_agotado_empty2", int'(agt[1]), agot_model(1));

    // mid-dispense: a new credit is ignored, then reset aborts with no refund
    cv[0] = 1'b1; cr[0] = 3'd5; sl[0] = 2'd3; t0 = cyc;
    tick(); cv[0] = 1'b0;
    tick();
    chk("abort_motor_on", int'(mot[0]), 8);
    cv[0] = 1'b1; cr[0] = 3'd7; sl[0] = 2'd0;
    tick(); cv[0] = 1'b0;
    tick();
    chk("abort_no_second_motor", int'(mot[0]), 8);
    #1 reset = 1'b0;
    #1;
    chk("abort_motor_off", int'(mot[0]), 0);
    chk("abort_ocupado", int'(ocup[0]), 0);
    chk("abort_moneda", int'(mon[0]), 0);
    for (int d = 0; d < 2; d++) for (int i = 0; i < 4; i++) stk[d][i] = smax(d);
    chk("abort_d1_agotado", int'(agt[1]), agot_model(1));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    coins = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (mon[0] || ocup[0]) coins++;
    end
    chk("abort_no_refund", coins, 0);

    buy(0, 3, 3, 1, 0, 0);
    chk("sb_drained", sb.size(), 0);
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
    $finish;
  end

endmodule
